// File: rtl/gate_stim_checker.sv
// Built-in self-test companion for a 2-input basic gate: drives {a,b}
// through the full truth table ROUNDS times, waits SETTLE_CYC cycles per
// vector, compares dut_y_i against the selected op and tallies mismatches.
// Optional feature macro: GATE_CHK_LFSR_EN selects the vector from the low
// two bits of an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5)
// instead of the sequential 00,01,10,11 order.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start_i; dut_a/dut_b keep the last vector
// S_DRIVE  | new vector just launched on dut_a/dut_b, settle counter loaded
// S_SETTLE | down-counting SETTLE_CYC cycles with the vector held
// S_CHECK  | compare dut_y_i to the expected gate output, pick next vector
// S_DONE   | one-cycle done pulse, pass result published
module gate_stim_checker #(
    parameter int SETTLE_CYC = 2,
    parameter int ROUNDS     = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_sel_i,
    output logic             dut_a_o,
    output logic             dut_b_o,
    input  logic             dut_y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             first_err_vld_o,
    output logic [1:0]       first_err_vec_o
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    localparam logic [RW-1:0]    ROUND_LAST  = RW'(ROUNDS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       op_q, op_d;
    logic [1:0]       idx_q, idx_d;
    logic [RW-1:0]    round_q, round_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ferr_vld_q, ferr_vld_d;
    logic [1:0]       ferr_vec_q, ferr_vec_d;
    logic             pass_q, pass_d;
    logic             dut_a_q, dut_a_d;
    logic             dut_b_q, dut_b_d;
    logic [1:0]       cur_vec;
    logic [1:0]       nvec;
    logic             mismatch;

`ifdef GATE_CHK_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    assign cur_vec = lfsr_q[1:0];
`else
    assign cur_vec = idx_q;
`endif

    // Reference behaviour of the gate under test; reserved ops never reach CHECK.
    function automatic logic gate_eval(input logic [2:0] op, input logic a, input logic b);
        logic y;
        case (op)
            3'd0:    y = a & b;
            3'd1:    y = a | b;
            3'd2:    y = a ^ b;
            3'd3:    y = ~(a & b);
            3'd4:    y = ~(a | b);
            3'd5:    y = ~(a ^ b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state, vector sequencing and result bookkeeping.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        round_d    = round_q;
        settle_d   = settle_q;
        err_d      = err_q;
        ferr_vld_d = ferr_vld_q;
        ferr_vec_d = ferr_vec_q;
        pass_d     = pass_q;
        dut_a_d    = dut_a_q;
        dut_b_d    = dut_b_q;
        mismatch   = 1'b0;
        nvec       = 2'b00;
`ifdef GATE_CHK_LFSR_EN
        lfsr_d     = lfsr_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d       = op_sel_i;
                    err_d      = '0;
                    ferr_vld_d = 1'b0;
                    ferr_vec_d = 2'b00;
                    pass_d     = 1'b0;
                    idx_d      = 2'b00;
                    round_d    = '0;
`ifdef GATE_CHK_LFSR_EN
                    lfsr_d     = 8'hA5;
`endif
                    state_d    = (op_sel_i < 3'd6) ? S_DRIVE : S_DONE;
                end
            end
            S_DRIVE: begin
                settle_d = SETTLE_LOAD;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) state_d  = S_CHECK;
                else                settle_d = settle_q - SW'(1);
            end
            S_CHECK: begin
                mismatch = (dut_y_i != gate_eval(op_q, cur_vec[1], cur_vec[0]));
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                    if (!ferr_vld_q) begin
                        ferr_vld_d = 1'b1;
                        ferr_vec_d = cur_vec;
                    end
                end
`ifdef GATE_CHK_LFSR_EN
                lfsr_d = lfsr_step(lfsr_q);
`endif
                if (idx_q == 2'd3 && round_q == ROUND_LAST) begin
                    pass_d  = (err_d == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) round_d = round_q + RW'(1);
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef GATE_CHK_LFSR_EN
        nvec = lfsr_d[1:0];
`else
        nvec = idx_d;
`endif
        // DRIVE lasts one cycle, so this only fires on entry to it.
        if (state_d == S_DRIVE) begin
            dut_a_d = nvec[1];
            dut_b_d = nvec[0];
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q       <= 3'd0;
            idx_q      <= 2'b00;
            round_q    <= '0;
            settle_q   <= '0;
            err_q      <= '0;
            ferr_vld_q <= 1'b0;
            ferr_vec_q <= 2'b00;
            pass_q     <= 1'b0;
            dut_a_q    <= 1'b0;
            dut_b_q    <= 1'b0;
`ifdef GATE_CHK_LFSR_EN
            lfsr_q     <= 8'hA5;
`endif
        end else begin
            op_q       <= op_d;
            idx_q      <= idx_d;
            round_q    <= round_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            ferr_vld_q <= ferr_vld_d;
            ferr_vec_q <= ferr_vec_d;
            pass_q     <= pass_d;
            dut_a_q    <= dut_a_d;
            dut_b_q    <= dut_b_d;
`ifdef GATE_CHK_LFSR_EN
            lfsr_q     <= lfsr_d;
`endif
        end
    end

    assign busy_o          = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done_o          = (state_q == S_DONE);
    assign pass_o          = pass_q;
    assign err_cnt_o       = err_q;
    assign first_err_vld_o = ferr_vld_q;
    assign first_err_vec_o = ferr_vec_q;
    assign dut_a_o         = dut_a_q;
    assign dut_b_o         = dut_b_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: a behavioural gate (golden or faulty) closes
// the loop on dut_a/dut_b -> dut_y; each run's expected outcome is computed
// from truth tables and queued, and a monitor compares on every done pulse.
// A second instance with ERR_W=2 covers error-counter saturation.
module tb_gate_stim_checker;

    localparam int SETTLE_CYC = 2;
    localparam int ROUNDS     = 4;
    localparam int N_VEC      = 4 * ROUNDS;
    localparam int N_BUSY     = N_VEC * (SETTLE_CYC + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, dut_a, dut_b, dut_y, busy, done, pass, fev;
    logic [2:0] op_sel;
    logic [7:0] err_cnt;
    logic [1:0] fvec;
    logic [2:0] dut_gate;

    logic       start1, dut_a1, dut_b1, busy1, done1, pass1, fev1;
    logic       dut_y1;
    logic [1:0] err1, fvec1;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int pops_at_launch = 0;
    int busy_cnt = 0;

    typedef struct {
        int         busy_len;
        int         err;
        logic       pass;
        logic       vld;
        logic [1:0] vec;
    } exp_t;

    exp_t exp_q[$];

    // Truth table per gate; 6 = stuck-at-0 DUT, 7 = stuck-at-1 DUT.
    function automatic logic ref_gate(input logic [2:0] g, input logic [1:0] v);
        logic [3:0] t;
        case (g)
            3'd0:    t = 4'b1000;
            3'd1:    t = 4'b1110;
            3'd2:    t = 4'b0110;
            3'd3:    t = 4'b0111;
            3'd4:    t = 4'b0001;
            3'd5:    t = 4'b1001;
            3'd6:    t = 4'b0000;
            default: t = 4'b1111;
        endcase
        return t[v];
    endfunction

    function automatic logic [1:0] vec_at(input int k);
`ifdef GATE_CHK_LFSR_EN
        logic [7:0] l;
        l = 8'hA5;
        for (int i = 0; i < k; i++) l = {l[6:0], ^(l & 8'hB8)};
        return l[1:0];
`else
        return 2'(k % 4);
`endif
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [2:0] g);
        exp_t e;
        int   errs;
        logic [1:0] v;
        e.busy_len = 0; e.err = 0; e.pass = 1'b0; e.vld = 1'b0; e.vec = 2'b00;
        if (op > 3'd5) return e;
        errs = 0;
        for (int k = 0; k < N_VEC; k++) begin
            v = vec_at(k);
            if (ref_gate(g, v) != ref_gate(op, v)) begin
                if (errs == 0) begin e.vld = 1'b1; e.vec = v; end
                errs++;
            end
        end
        e.busy_len = N_BUSY;
        e.err      = (errs > 255) ? 255 : errs;
        e.pass     = (errs == 0);
        return e;
    endfunction

    assign dut_y  = ref_gate(dut_gate, {dut_a, dut_b});
    assign dut_y1 = 1'b0;

    gate_stim_checker #(.SETTLE_CYC(SETTLE_CYC), .ROUNDS(ROUNDS), .ERR_W(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_sel_i(op_sel),
        .dut_a_o(dut_a), .dut_b_o(dut_b), .dut_y_i(dut_y),
        .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
        .first_err_vld_o(fev), .first_err_vec_o(fvec)
    );

    gate_stim_checker #(.SETTLE_CYC(SETTLE_CYC), .ROUNDS(ROUNDS), .ERR_W(2)) u_dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .op_sel_i(3'd3),
        .dut_a_o(dut_a1), .dut_b_o(dut_b1), .dut_y_i(dut_y1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_cnt_o(err1),
        .first_err_vld_o(fev1), .first_err_vec_o(fvec1)
    );

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy_len", busy_cnt, e.busy_len);
                        chk("err_cnt", int'(err_cnt), e.err);
                        chk("pass", int'(pass), int'(e.pass));
                        chk("first_err_vld", int'(fev), int'(e.vld));
                        chk("first_err_vec", int'(fvec), int'(e.vec));
                    end
                    pops++;
                    busy_cnt = 0;
                end
            end
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic [2:0] g, input bit push);
        @(negedge clk);
        pops_at_launch = pops;
        op_sel   = op;
        dut_gate = g;
        start    = 1'b1;
        if (push) exp_q.push_back(model(op, g));
        @(negedge clk);
        start = 1'b0;
        if (op < 3'd6) begin
            chk("busy_after_accept", int'(busy), 1);
            chk("first_vector", int'({dut_a, dut_b}), int'(vec_at(0)));
        end else begin
            chk("reserved_done_latency", int'(done), 1);
            chk("reserved_busy", int'(busy), 0);
        end
    endtask

    task automatic wait_done(input int limit, input bit noise);
        int n;
        n = 0;
        while (pops == pops_at_launch && n < limit) begin
            @(negedge clk);
            n++;
            if (noise) begin
                op_sel = 3'($urandom_range(0, 7));
                start  = (n < 20 && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        start = 1'b0;
        if (pops == pops_at_launch) chk("done_timeout", 0, 1);
    endtask

    initial begin
        logic [2:0] rop, rg;
        int n;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; op_sel = 3'd0; dut_gate = 3'd0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_ab", int'({dut_a, dut_b}), 0);
        chk("rst_fev", int'(fev), 0);
        rst = 1'b0;

        // Golden OR, stuck-at-1 under AND, reserved ops, golden XOR.
        launch(3'd1, 3'd1, 1'b1); wait_done(200, 1'b0);
        launch(3'd0, 3'd7, 1'b1); wait_done(200, 1'b0);
        launch(3'd6, 3'd1, 1'b1); wait_done(20, 1'b0);
        launch(3'd7, 3'd0, 1'b1); wait_done(20, 1'b0);
        launch(3'd2, 3'd2, 1'b1); wait_done(200, 1'b0);

        // Abort a faulty run with reset; no done may follow.
        launch(3'd0, 3'd7, 1'b0);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_err", int'(err_cnt), 0);
        chk("midrst_fev", int'(fev), 0);
        chk("midrst_ab", int'({dut_a, dut_b}), 0);
        repeat (100) @(negedge clk);

        // start held high while busy must not restart or queue a run.
        launch(3'd0, 3'd0, 1'b1);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(200, 1'b0);
        repeat (10) @(negedge clk);

        // Randomized runs with op_sel and start noise mid-run.
        for (int r = 0; r < 12; r++) begin
            rop = 3'($urandom_range(0, 7));
            rg  = ($urandom_range(0, 1) == 1) ? rop : 3'($urandom_range(0, 7));
            launch(rop, rg, 1'b1);
            wait_done(200, 1'b1);
        end

        // Saturation on the narrow-counter instance: NAND vs stuck-at-0.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sat_done_seen", int'(done1), 1);
        chk("sat_err_cnt", int'(err1), 3);
        chk("sat_pass", int'(pass1), 0);
        chk("sat_fev", int'(fev1), 1);
        chk("sat_fvec", int'(fvec1), 0);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
